// File: rtl/bsg_logic3_rr_share_pkg.sv
// Shared definitions for the round-robin shared 3-input logic unit.
package bsg_logic3_rr_share_pkg;

    // Width of the per-requester op field.
    localparam int op_width_lp = 2;

    // Op encoding presented by each requester.
    typedef enum logic [op_width_lp-1:0] {
        e_nor3 = 2'b00,
        e_or3  = 2'b01,
        e_and3 = 2'b10,
        e_xor3 = 2'b11
    } op_e;

endpackage

// File: rtl/bsg_arb_rr_ptr.sv
// Combinational round-robin pick: first request at or after the pointer wins.
module bsg_arb_rr_ptr #(
    parameter int num_req_p   = 4,
    parameter int id_width_lp = 2
) (
    input  logic [num_req_p-1:0]   i_reqs,
    input  logic [id_width_lp-1:0] i_ptr,
    input  logic                   i_en,
    output logic [num_req_p-1:0]   o_grant,
    output logic [id_width_lp-1:0] o_grant_id,
    output logic                   o_grant_v
);

    int   w_dist;
    int   w_best;
    int   w_sel;
    logic w_found;

    // Each requester's priority is its distance past the pointer; smallest distance wins.
    always_comb begin
        w_dist  = 0;
        w_best  = num_req_p;
        w_sel   = 0;
        w_found = 1'b0;
        for (int j = 0; j < num_req_p; j++) begin
            w_dist = j - int'(i_ptr);
            if (w_dist < 0) w_dist = w_dist + num_req_p;
            if (i_reqs[j] && (w_dist < w_best)) begin
                w_best  = w_dist;
                w_sel   = j;
                w_found = 1'b1;
            end
        end
    end

    // Grant is suppressed entirely when the consumer cannot take an op.
    always_comb begin
        o_grant_v  = w_found & i_en;
        o_grant_id = id_width_lp'(w_sel);
        o_grant    = '0;
        for (int j = 0; j < num_req_p; j++) begin
            o_grant[j] = o_grant_v && (w_sel == j);
        end
    end

endmodule

// File: rtl/bsg_logic3_rr_share.sv
// One registered NOR3/OR3/AND3/XOR3 slice shared round-robin among requesters.
module bsg_logic3_rr_share
    import bsg_logic3_rr_share_pkg::*;
#(
    parameter  int width_p     = 32,
    parameter  int num_req_p   = 4,
    localparam int id_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [num_req_p-1:0]           v_i,
    input  logic [num_req_p*width_p-1:0]   a_i,
    input  logic [num_req_p*width_p-1:0]   b_i,
    input  logic [num_req_p*width_p-1:0]   c_i,
    input  logic [num_req_p*op_width_lp-1:0] op_i,
    output logic [num_req_p-1:0]           yumi_o,
    output logic                           v_o,
    output logic [width_p-1:0]             data_o,
    output logic [id_width_lp-1:0]         id_o,
    input  logic                           ready_i
);

    logic                   r_v;
    logic [width_p-1:0]     r_data;
    logic [id_width_lp-1:0] r_id;
    logic [id_width_lp-1:0] r_ptr;

    logic                   w_can_accept;
    logic [num_req_p-1:0]   w_grant;
    logic [id_width_lp-1:0] w_grant_id;
    logic                   w_grant_v;
    logic [width_p-1:0]     w_a;
    logic [width_p-1:0]     w_b;
    logic [width_p-1:0]     w_c;
    logic [op_width_lp-1:0] w_op;
    logic [width_p-1:0]     w_result;

    // A draining output register frees its slot in the same cycle, so no bubbles.
    assign w_can_accept = ~r_v | ready_i;

    bsg_arb_rr_ptr #(
        .num_req_p   (num_req_p),
        .id_width_lp (id_width_lp)
    ) u_arb (
        .i_reqs     (v_i),
        .i_ptr      (r_ptr),
        .i_en       (w_can_accept & ~reset_i),
        .o_grant    (w_grant),
        .o_grant_id (w_grant_id),
        .o_grant_v  (w_grant_v)
    );

    assign yumi_o = w_grant;

    // One-hot operand mux driven by the grant vector.
    always_comb begin
        w_a  = '0;
        w_b  = '0;
        w_c  = '0;
        w_op = '0;
        for (int k = 0; k < num_req_p; k++) begin
            if (w_grant[k]) begin
                w_a  = a_i[k*width_p +: width_p];
                w_b  = b_i[k*width_p +: width_p];
                w_c  = c_i[k*width_p +: width_p];
                w_op = op_i[k*op_width_lp +: op_width_lp];
            end
        end
    end

    // Bitwise 3-input logic function selected by the winner's op.
    always_comb begin
        unique case (op_e'(w_op))
            e_nor3:  w_result = ~(w_a | w_b | w_c);
            e_or3:   w_result = w_a | w_b | w_c;
            e_and3:  w_result = w_a & w_b & w_c;
            default: w_result = w_a ^ w_b ^ w_c;
        endcase
    end

    // Output register and round-robin pointer; pointer moves just past the winner.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_v    <= 1'b0;
            r_data <= '0;
            r_id   <= '0;
            r_ptr  <= '0;
        end else if (w_grant_v) begin
            r_v    <= 1'b1;
            r_data <= w_result;
            r_id   <= w_grant_id;
            if (w_grant_id == id_width_lp'(num_req_p - 1)) r_ptr <= '0;
            else                                           r_ptr <= w_grant_id + id_width_lp'(1);
        end else if (ready_i) begin
            r_v <= 1'b0;
        end
    end

    assign v_o    = r_v;
    assign data_o = r_data;
    assign id_o   = r_id;

endmodule

// File: tb/tb_bsg_logic3_rr_share.sv
// Self-checking bench: directed scenarios plus randomized traffic against a cycle model.
module tb_bsg_logic3_rr_share;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   v;
    logic [N*W-1:0] a, b, c;
    logic [2*N-1:0] op;
    logic           ready;
    logic [N-1:0]   yumi;
    logic           v_o;
    logic [W-1:0]   data_o;
    logic [1:0]     id_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bsg_logic3_rr_share #(.width_p(W), .num_req_p(N)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .v_i     (v),
        .a_i     (a),
        .b_i     (b),
        .c_i     (c),
        .op_i    (op),
        .yumi_o  (yumi),
        .v_o     (v_o),
        .data_o  (data_o),
        .id_o    (id_o),
        .ready_i (ready)
    );

    // ---------------- reference model ----------------
    logic         mdl_v    = 1'b0;
    logic [W-1:0] mdl_data = '0;
    int           mdl_id   = 0;
    int           mdl_ptr  = 0;
    logic [N-1:0] mdl_y;
    int           mdl_k;

    function automatic logic [W-1:0] ref_op(logic [1:0] o, logic [W-1:0] x, logic [W-1:0] y, logic [W-1:0] z);
        logic [W-1:0] any1, all1, par;
        any1 = x | y | z;
        all1 = x & y & z;
        par  = x ^ y ^ z;
        if (o == 2'd0) return ~any1;
        if (o == 2'd1) return any1;
        if (o == 2'd2) return all1;
        return par;
    endfunction

    function automatic logic [N-1:0] exp_yumi();
        logic [N-1:0] r;
        r = '0;
        if (!rst && (!mdl_v || ready)) begin
            for (int i = 0; i < N; i++) begin
                if (r == '0 && v[(mdl_ptr + i) % N]) r[(mdl_ptr + i) % N] = 1'b1;
            end
        end
        return r;
    endfunction

    always_comb mdl_y = exp_yumi();

    always_comb begin
        mdl_k = 0;
        for (int i = 0; i < N; i++) if (mdl_y[i]) mdl_k = i;
    end

    always @(posedge clk) begin
        if (rst) begin
            mdl_v    <= 1'b0;
            mdl_data <= '0;
            mdl_id   <= 0;
            mdl_ptr  <= 0;
        end else if (mdl_y != '0) begin
            mdl_v    <= 1'b1;
            mdl_data <= ref_op(op[2*mdl_k +: 2], a[W*mdl_k +: W], b[W*mdl_k +: W], c[W*mdl_k +: W]);
            mdl_id   <= mdl_k;
            mdl_ptr  <= (mdl_k + 1) % N;
        end else if (ready) begin
            mdl_v <= 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(int k, logic [1:0] o, logic [W-1:0] x, logic [W-1:0] y, logic [W-1:0] z);
        op[2*k +: 2] = o;
        a[W*k +: W]  = x;
        b[W*k +: W]  = y;
        c[W*k +: W]  = z;
    endtask

    task automatic do_reset();
        rst = 1'b1; v = '0; ready = 1'b1;
        next_cyc();
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; v = 4'b1111; ready = 1'b1;
        a = '0; b = '0; c = '0; op = '0;
        next_cyc();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (yumi !== 4'b0000) begin errors++; $display("FAIL reset_yumi got %b exp 0000", yumi); end
            checks++;
            if (v_o !== 1'b0 || data_o !== '0 || id_o !== 2'd0) begin
                errors++; $display("FAIL reset_out got v=%b d=%h id=%0d exp 0/0/0", v_o, data_o, id_o);
            end
            next_cyc();
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (yumi !== 4'b0001) begin errors++; $display("FAIL reset_release_yumi got %b exp 0001", yumi); end
        next_cyc();
    endtask

    task automatic test_single();
        v = 4'b0100; ready = 1'b1;
        set_req(2, 2'b00, '0, '0, '0);
        @(negedge clk);
        checks++;
        if (yumi !== 4'b0100) begin errors++; $display("FAIL single_yumi got %b exp 0100", yumi); end
        next_cyc();
        v = '0;
        @(negedge clk);
        checks++;
        if (v_o !== 1'b1 || data_o !== 32'hFFFFFFFF || id_o !== 2'd2) begin
            errors++; $display("FAIL single_out got v=%b d=%h id=%0d exp 1/ffffffff/2", v_o, data_o, id_o);
        end
        next_cyc();
    endtask

    task automatic test_ops();
        logic [W-1:0] exp_tab [4];
        exp_tab[0] = 32'h000F000E;
        exp_tab[1] = 32'hFFF0FFF1;
        exp_tab[2] = 32'h00000000;
        exp_tab[3] = 32'hFF00FF01;
        for (int o = 0; o < 4; o++) begin
            v = 4'b0010; ready = 1'b1;
            set_req(1, 2'(o), 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00000001);
            @(negedge clk);
            checks++;
            if (yumi !== 4'b0010) begin errors++; $display("FAIL op%0d_yumi got %b exp 0010", o, yumi); end
            next_cyc();
            v = '0;
            @(negedge clk);
            checks++;
            if (v_o !== 1'b1 || data_o !== exp_tab[o] || id_o !== 2'd1) begin
                errors++; $display("FAIL op%0d_data got v=%b d=%h id=%0d exp 1/%h/1", o, v_o, data_o, id_o, exp_tab[o]);
            end
            next_cyc();
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        v = 4'b1111; ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < N; k++) set_req(k, 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom);
            @(negedge clk);
            checks++;
            if (yumi !== 4'(1 << (i % 4))) begin
                errors++; $display("FAIL rr_grant%0d got %b exp %b", i, yumi, 4'(1 << (i % 4)));
            end
            if (i >= 1) begin
                checks++;
                if (v_o !== 1'b1 || id_o !== 2'((i - 1) % 4) || data_o !== mdl_data) begin
                    errors++; $display("FAIL rr_out%0d got v=%b id=%0d d=%h exp 1/%0d/%h", i, v_o, id_o, data_o, (i - 1) % 4, mdl_data);
                end
            end
            next_cyc();
        end
        v = '0;
        next_cyc();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held;
        do_reset();
        v = 4'b0001; ready = 1'b1;
        set_req(0, 2'b11, 32'h12345678, 32'h0F0F0F0F, 32'hFFFF0000);
        set_req(1, 2'b01, 32'h00000011, 32'h00000022, 32'h00000044);
        held = 32'h12345678 ^ 32'h0F0F0F0F ^ 32'hFFFF0000;
        @(negedge clk);
        next_cyc();
        v = 4'b0011; ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (yumi !== 4'b0000) begin errors++; $display("FAIL bp_yumi%0d got %b exp 0000", i, yumi); end
            checks++;
            if (v_o !== 1'b1 || id_o !== 2'd0 || data_o !== held) begin
                errors++; $display("FAIL bp_hold%0d got v=%b id=%0d d=%h exp 1/0/%h", i, v_o, id_o, data_o, held);
            end
            next_cyc();
        end
        ready = 1'b1;
        @(negedge clk);
        checks++;
        if (yumi !== 4'b0010) begin errors++; $display("FAIL bp_release_yumi got %b exp 0010", yumi); end
        next_cyc();
        v = '0;
        @(negedge clk);
        checks++;
        if (v_o !== 1'b1 || id_o !== 2'd1 || data_o !== 32'h00000077) begin
            errors++; $display("FAIL bp_release_out got v=%b id=%0d d=%h exp 1/1/00000077", v_o, id_o, data_o);
        end
        next_cyc();
    endtask

    task automatic test_reset_mid();
        do_reset();
        v = 4'b0100; ready = 1'b1;
        set_req(2, 2'b01, 32'hA5A5A5A5, '0, '0);
        next_cyc();
        v = '0; ready = 1'b0;
        @(negedge clk);
        checks++;
        if (v_o !== 1'b1 || id_o !== 2'd2) begin errors++; $display("FAIL mid_setup got v=%b id=%0d exp 1/2", v_o, id_o); end
        next_cyc();
        rst = 1'b1; v = 4'b1001;
        @(negedge clk);
        checks++;
        if (yumi !== 4'b0000) begin errors++; $display("FAIL mid_rst_yumi got %b exp 0000", yumi); end
        next_cyc();
        rst = 1'b0; ready = 1'b1;
        @(negedge clk);
        checks++;
        if (v_o !== 1'b0 || yumi !== 4'b0001) begin
            errors++; $display("FAIL mid_after got v=%b yumi=%b exp 0/0001", v_o, yumi);
        end
        next_cyc();
        v = '0;
        @(negedge clk);
        checks++;
        if (v_o !== 1'b1 || id_o !== 2'd0) begin errors++; $display("FAIL mid_grant got v=%b id=%0d exp 1/0", v_o, id_o); end
        next_cyc();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 99) < 2);
            ready = ($urandom_range(0, 99) < 70);
            v     = 4'($urandom);
            for (int k = 0; k < N; k++) set_req(k, 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom);
            @(negedge clk);
            checks++;
            if (yumi !== mdl_y) begin errors++; $display("FAIL rand_yumi@%0d got %b exp %b", i, yumi, mdl_y); end
            checks++;
            if (v_o !== mdl_v || data_o !== mdl_data || id_o !== 2'(mdl_id)) begin
                errors++; $display("FAIL rand_out@%0d got v=%b d=%h id=%0d exp %b/%h/%0d", i, v_o, data_o, id_o, mdl_v, mdl_data, mdl_id);
            end
            next_cyc();
        end
        rst = 1'b0; v = '0; ready = 1'b1;
        next_cyc();
    endtask

    initial begin
        test_reset();
        test_single();
        test_ops();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
